// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC, IF/ID register, fetch counter
// Optional feature macro: BRANCH_DELAY_SLOT_EN (delay-slot instruction captured on redirect)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [8:0]  imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_plus4;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc[10:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            if_id_inst  <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            fetch_count <= 32'd0;
        end else if (!stall) begin
            if (redirect_valid) begin
                pc <= {redirect_target[31:2], 2'b00};
`ifdef BRANCH_DELAY_SLOT_EN
                if_id_inst  <= imem_rdata;
                if_id_pc4   <= pc_plus4;
                if_id_valid <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
`else
                // Delay slot squashed: inject a NOP bubble into decode.
                if_id_inst  <= 32'd0;
                if_id_pc4   <= 32'd0;
                if_id_valid <= 1'b0;
`endif
            end else begin
                pc          <= pc_plus4;
                if_id_inst  <= imem_rdata;
                if_id_pc4   <= pc_plus4;
                if_id_valid <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline. Holds the program counter and drives the 9-bit word address of the 512-word instruction memory. Captures the combinational read data into the IF/ID pipeline register together with PC+4. Handles sequential fetch, decode-stage stall and branch/jump redirect, and keeps a count of fetched instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold PC and IF/ID this cycle (load-use hazard from ID)
- redirect_valid  in  1  taken branch/jump resolved in ID
- redirect_target  in  32  byte target address of the redirect
- imem_addr  out  9  word address to instruction memory, = pc[10:2]
- imem_rdata  in  32  instruction word; combinational function of imem_addr, valid in the same cycle
- pc  out  32  current fetch PC (byte address)
- if_id_inst  out  32  registered instruction to decode
- if_id_pc4  out  32  registered PC+4 of if_id_inst
- if_id_valid  out  1  if_id_inst is a real instruction (0 = bubble)
- fetch_count  out  32  number of instructions captured with valid=1 since reset

## Operation
- Reset (async, while reset=1): pc=RESET_PC, if_id_inst=0, if_id_pc4=0, if_id_valid=0, fetch_count=0. The first capture happens at the first rising edge after reset deasserts.
- imem_addr is always pc[10:2] (combinational). PC bits [31:11] are carried but ignored by memory, so addresses alias modulo 2 KB.
- Per rising edge, evaluated in priority order:
  1. stall=1: pc, if_id_* and fetch_count hold. redirect_valid is ignored; the ID stage keeps asserting it until stall clears.
  2. redirect_valid=1: pc <= {redirect_target[31:2], 2'b00}, with the low bits forced to 0. IF/ID handling depends on the configuration.
  3. Otherwise: pc <= pc+4; if_id_inst <= imem_rdata, if_id_pc4 <= pc+4, if_id_valid <= 1; fetch_count += 1.
- pc+4 arithmetic is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- fetch_count wraps from 32'hFFFF_FFFF to 0.

## Timing
- Fetch latency is 1 cycle: the word addressed by pc in cycle N appears on if_id_inst after edge N.
- Throughput is 1 instruction per cycle when there is no stall or redirect.
- A redirect in cycle N changes imem_addr to the target in cycle N+1. The target instruction reaches IF/ID after edge N+1.
- Stall has no latency cost beyond the stalled cycles. Outputs are bit-identical across stall cycles.
- A reset assertion mid-operation takes effect immediately, without waiting for clk. Any pending redirect is discarded.

## Configuration
- Macro BRANCH_DELAY_SLOT_EN.
- Defined: MIPS delay-slot semantics. On a redirect edge the instruction at the current pc (the delay slot) is captured normally: if_id_inst <= imem_rdata, if_id_pc4 <= pc+4, if_id_valid <= 1, fetch_count += 1.
- Undefined: the delay-slot instruction is squashed. On a redirect edge: if_id_inst <= 0 (NOP), if_id_pc4 <= 0, if_id_valid <= 0, fetch_count unchanged.
- PC update is identical in both builds.

## Test plan
All scenarios use RESET_PC=0 and memory words 0=0x20080005, 1=0x20090003, 2=0x01095020, 3=0x00000000, 16=0x2008FFFF.
1. Release reset, no stall or redirect, 3 edges: IF/ID sequence is (0x20080005, pc4 4), (0x20090003, 8), (0x01095020, 12), all with valid=1. imem_addr steps 0,1,2,3; fetch_count=3.
2. At pc=8 hold stall=1 for 2 edges: pc stays 8, IF/ID stays (0x20090003, 8, 1), fetch_count stays 2. After stall release the next edge captures 0x01095020.
3. Macro undefined, at pc=12 pulse redirect_valid with target 0x40: after the edge pc=0x40, imem_addr=16, if_id_valid=0, if_id_inst=0. The next edge captures 0x2008FFFF with pc4 0x44.
4. Macro defined, same stimulus as 3: the redirect edge captures 0x00000000, valid=1, pc4 16, fetch_count increments. pc=0x40.
5. stall=1 and redirect_valid=1 (target 0x40) together: pc unchanged. Drop stall and keep redirect for 1 edge: pc=0x40. Target 0x43 loads pc=0x40.
6. Assert reset asynchronously between edges mid-run: pc=0, if_id_valid=0, if_id_inst=0 and fetch_count=0 immediately, without waiting for clk. After release, scenario 1's sequence repeats.
